// File: rtl/pipeline_hazard_ctrl.sv
// EX-stage hazard control for the 5-stage RV32I pipeline.
// Resolves branches and jumps, computes the EX operand forwarding selects, and
// detects load-use and branch-after-load stalls. The only registered logic is a
// one-cycle-delayed flush flag and two saturating performance counters.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   cur_pc, imm             PC and sign-extended immediate of the EX instruction
//   alu_result              EX ALU output (bit0 = branch condition, full = JALR target)
//   branch_taken, jalr_sel  EX holds a branch/JAL, EX holds JALR
//   ex_branch               EX holds a conditional branch
//   pc_plus_4, imm_out      link value and AUIPC value (combinational)
//   branch_target, pc_sel   redirect PC and redirect/flush request (combinational)
//   rs1_ex, rs2_ex          EX source registers
//   ex_mem_rd/_regwrite     MEM destination and write enable
//   mem_wb_rd/_regwrite     WB destination and write enable
//   forward_a, forward_b    operand selects: 00 regfile, 01 WB, 10 MEM (combinational)
//   if_id_rs1, if_id_rs2    ID source registers
//   id_ex_rd, id_ex_memread EX destination and EX-is-load
//   branch_id, memtoreg_mem ID holds branch/jump, MEM holds a load
//   stall                   hold PC and IF/ID, bubble ID/EX (combinational)
//   flush_q                 pc_sel delayed one cycle (registered)
//   stall_cnt, flush_cnt    saturating stall-cycle and redirect counters (registered)
module pipeline_hazard_ctrl #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] cur_pc,
   input  logic [DATA_W-1:0] imm,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              branch_taken,
   input  logic              jalr_sel,
   input  logic              ex_branch,
   output logic [DATA_W-1:0] pc_plus_4,
   output logic [DATA_W-1:0] imm_out,
   output logic [DATA_W-1:0] branch_target,
   output logic              pc_sel,
   input  logic [4:0]        rs1_ex,
   input  logic [4:0]        rs2_ex,
   input  logic [4:0]        ex_mem_rd,
   input  logic              ex_mem_regwrite,
   input  logic [4:0]        mem_wb_rd,
   input  logic              mem_wb_regwrite,
   output logic [1:0]        forward_a,
   output logic [1:0]        forward_b,
   input  logic [4:0]        if_id_rs1,
   input  logic [4:0]        if_id_rs2,
   input  logic [4:0]        id_ex_rd,
   input  logic              id_ex_memread,
   input  logic              branch_id,
   input  logic              memtoreg_mem,
   output logic              stall,
   output logic              flush_q,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic load_use;
   logic br_load;

   // Forward select for one source register; MEM result beats WB data, x0 never forwards.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] mem_rd,
                                          input logic       mem_we,
                                          input logic [4:0] wb_rd,
                                          input logic       wb_we);
      logic [1:0] sel;
      sel = FWD_RF;
      if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
         sel = FWD_MEM;
      end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

   // Branch / jump resolution; adders wrap modulo 2^DATA_W.
   always_comb begin
      pc_plus_4     = cur_pc + DATA_W'(4);
      imm_out       = cur_pc + imm;
      branch_target = imm_out;
      if (jalr_sel) begin
         branch_target = {alu_result[DATA_W-1:1], 1'b0};
      end
      pc_sel = jalr_sel | (branch_taken & alu_result[0]);
   end

   // Operand forwarding selects.
   always_comb begin
      forward_a = fwd_sel(rs1_ex, ex_mem_rd, ex_mem_regwrite, mem_wb_rd, mem_wb_regwrite);
      forward_b = fwd_sel(rs2_ex, ex_mem_rd, ex_mem_regwrite, mem_wb_rd, mem_wb_regwrite);
   end

   // Stall detection; a redirect or a branch resolving in EX suppresses the stall.
   always_comb begin
      load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                 ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
      br_load  = branch_id && memtoreg_mem && (ex_mem_rd != 5'd0) &&
                 ((ex_mem_rd == if_id_rs1) || (ex_mem_rd == if_id_rs2));
      stall    = (load_use | br_load) & ~pc_sel & ~ex_branch;
   end

   // Delayed flush flag and saturating event counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         flush_q   <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         flush_q <= pc_sel;
         if (stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (pc_sel && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

   logic        clock;
   logic        reset;
   logic [31:0] cur_pc, imm, alu_result;
   logic        branch_taken, jalr_sel, ex_branch;
   logic [31:0] pc_plus_4, imm_out, branch_target;
   logic        pc_sel;
   logic [4:0]  rs1_ex, rs2_ex, ex_mem_rd, mem_wb_rd;
   logic        ex_mem_regwrite, mem_wb_regwrite;
   logic [1:0]  forward_a, forward_b;
   logic [4:0]  if_id_rs1, if_id_rs2, id_ex_rd;
   logic        id_ex_memread, branch_id, memtoreg_mem;
   logic        stall, flush_q;
   logic [15:0] stall_cnt, flush_cnt;

   int n_cmp = 0;
   int n_err = 0;

   pipeline_hazard_ctrl #(.DATA_W(32), .CNT_W(16)) dut (
      .clock(clock), .reset(reset),
      .cur_pc(cur_pc), .imm(imm), .alu_result(alu_result),
      .branch_taken(branch_taken), .jalr_sel(jalr_sel), .ex_branch(ex_branch),
      .pc_plus_4(pc_plus_4), .imm_out(imm_out), .branch_target(branch_target),
      .pc_sel(pc_sel),
      .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .ex_mem_rd(ex_mem_rd),
      .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_rd(mem_wb_rd),
      .mem_wb_regwrite(mem_wb_regwrite),
      .forward_a(forward_a), .forward_b(forward_b),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .id_ex_rd(id_ex_rd),
      .id_ex_memread(id_ex_memread), .branch_id(branch_id),
      .memtoreg_mem(memtoreg_mem),
      .stall(stall), .flush_q(flush_q),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      cur_pc = '0; imm = '0; alu_result = '0;
      branch_taken = 0; jalr_sel = 0; ex_branch = 0;
      rs1_ex = 0; rs2_ex = 0; ex_mem_rd = 0; mem_wb_rd = 0;
      ex_mem_regwrite = 0; mem_wb_regwrite = 0;
      if_id_rs1 = 0; if_id_rs2 = 0; id_ex_rd = 0;
      id_ex_memread = 0; branch_id = 0; memtoreg_mem = 0;

      // Reset state
      #12;
      chk("rst_flush_q",   32'(flush_q),   32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      chk("rst_pc_plus_4", pc_plus_4,      32'h4);
      reset = 1'b1;
      tick();
      chk("idle_flush_cnt", 32'(flush_cnt), 32'd0);

      // Taken branch
      cur_pc = 32'h100; imm = 32'h20; branch_taken = 1; alu_result = 32'h1;
      #1;
      chk("br_pc_sel",   32'(pc_sel),   32'd1);
      chk("br_target",   branch_target, 32'h120);
      chk("br_pc4",      pc_plus_4,     32'h104);
      chk("br_imm_out",  imm_out,       32'h120);
      tick();
      chk("br_flush_q",   32'(flush_q),   32'd1);
      chk("br_flush_cnt", 32'(flush_cnt), 32'd1);

      // Not-taken branch
      alu_result = 32'h0;
      #1;
      chk("nt_pc_sel", 32'(pc_sel), 32'd0);
      tick();
      chk("nt_flush_q",   32'(flush_q),   32'd0);
      chk("nt_flush_cnt", 32'(flush_cnt), 32'd1);

      // JALR clears target bit 0
      branch_taken = 0; jalr_sel = 1; alu_result = 32'h2003;
      #1;
      chk("jalr_target", branch_target, 32'h2002);
      chk("jalr_pc_sel", 32'(pc_sel),   32'd1);
      tick();
      chk("jalr_flush_q",   32'(flush_q),   32'd1);
      chk("jalr_flush_cnt", 32'(flush_cnt), 32'd2);
      jalr_sel = 0; alu_result = 32'h0;

      // Modular adders
      cur_pc = 32'hFFFF_FFFE; imm = 32'h0000_0010;
      #1;
      chk("wrap_pc4", pc_plus_4, 32'h2);
      chk("wrap_imm", imm_out,   32'hE);
      cur_pc = 32'h100; imm = 32'hFFFF_FFF0;
      #1;
      chk("neg_imm", imm_out, 32'hF0);

      // Forwarding priority
      rs1_ex = 5; ex_mem_rd = 5; ex_mem_regwrite = 1; mem_wb_rd = 5; mem_wb_regwrite = 1;
      #1;
      chk("fwd_a_mem", 32'(forward_a), 32'd2);
      chk("fwd_b_rf",  32'(forward_b), 32'd0);
      ex_mem_regwrite = 0;
      #1;
      chk("fwd_a_wb", 32'(forward_a), 32'd1);
      rs2_ex = 9; mem_wb_rd = 9; ex_mem_regwrite = 1; ex_mem_rd = 9;
      #1;
      chk("fwd_b_mem", 32'(forward_b), 32'd2);
      chk("fwd_a_rf",  32'(forward_a), 32'd0);
      rs1_ex = 0; rs2_ex = 0; ex_mem_rd = 0; mem_wb_rd = 0;
      #1;
      chk("fwd_a_x0", 32'(forward_a), 32'd0);
      chk("fwd_b_x0", 32'(forward_b), 32'd0);
      ex_mem_regwrite = 0; mem_wb_regwrite = 0;

      // Load-use stall
      id_ex_memread = 1; id_ex_rd = 7; if_id_rs2 = 7;
      #1;
      chk("lu_stall", 32'(stall), 32'd1);
      tick();
      chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
      jalr_sel = 1; alu_result = 32'h400;
      #1;
      chk("lu_flush_wins", 32'(stall), 32'd0);
      tick();
      chk("lu_flush_stall_cnt", 32'(stall_cnt), 32'd1);
      chk("lu_flush_flush_cnt", 32'(flush_cnt), 32'd3);
      jalr_sel = 0; alu_result = 32'h0; ex_branch = 1;
      #1;
      chk("lu_exbr_supp", 32'(stall), 32'd0);
      ex_branch = 0; id_ex_rd = 0; if_id_rs2 = 0;
      #1;
      chk("lu_x0_nostall", 32'(stall), 32'd0);
      tick();
      chk("lu_x0_stall_cnt", 32'(stall_cnt), 32'd1);
      id_ex_memread = 0;

      // Branch after load in MEM
      branch_id = 1; memtoreg_mem = 1; ex_mem_rd = 3; if_id_rs1 = 3;
      #1;
      chk("brl_stall", 32'(stall), 32'd1);
      tick();
      chk("brl_stall_cnt", 32'(stall_cnt), 32'd2);

      // Asynchronous reset mid-run
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("mid_rst_flush_cnt", 32'(flush_cnt), 32'd0);
      chk("mid_rst_flush_q",   32'(flush_q),   32'd0);
      chk("mid_rst_comb_stall", 32'(stall),    32'd1);
      #3;
      reset = 1'b1;

      // Saturation: stall held for 2^16+3 cycles
      repeat (65534) @(posedge clock);
      #1;
      chk("sat_near", 32'(stall_cnt), 32'hFFFE);
      repeat (5) @(posedge clock);
      #1;
      chk("sat_full",  32'(stall_cnt), 32'hFFFF);
      chk("sat_flush", 32'(flush_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
